instr_mem_module: RTL and testbench

//  Instruction memory: the responder side of the CPU fetch interface. It returns
//  the word at instr_sel (the CPU PC) on instr_out (the CPU instr_in).
//  It also contains a byte-stream program loader with a valid/ready handshake.
//  The loader packs bytes into big-endian words and writes them from word 0 upward.

---
 rtl/instr_mem_module.sv | 154 +++++++++++++++
 tb/tb_instr_mem_module.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_module.sv
// Instruction memory with a zero-latency fetch port and a byte-stream program loader.
// Bytes are packed big-endian into words and written from word 0 upward while the CPU is held.
module instr_mem_module #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           instr_sel,
  output logic [31:0]           instr_out,
  output logic                  addr_fault,
  input  logic                  load_start,
  input  logic [7:0]            load_byte,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  load_end,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_ovf
);

  localparam int                DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;
  logic [31:0]           next_word;
  logic                  mem_full;

  logic [31:0] mem [DEPTH];

  // Fetch path: purely combinational so the CPU sees its instruction in the same cycle.
  assign addr_fault = (instr_sel[1:0] != 2'b00) || (instr_sel[31:ADDR_WIDTH+2] != '0);
  assign instr_out  = (addr_fault || cpu_hold) ? NOP_WORD : mem[instr_sel[ADDR_WIDTH+1:2]];

  assign mem_full   = (count_q == FULL_COUNT);
  assign load_count = count_q;
  assign load_ovf   = ovf_q;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    mem_we     = 1'b0;
    mem_waddr  = count_q[ADDR_WIDTH-1:0];
    mem_wdata  = word_q;
    next_word  = word_q;
    load_ready = 1'b0;
    cpu_hold   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LOAD;
          byte_idx_d = 2'd0;
          word_d     = '0;
          count_d    = '0;
          ovf_d      = 1'b0;
        end
      end

      LOAD: begin
        cpu_hold   = 1'b1;
        load_ready = !mem_full;
        if (load_start) begin
          // Restart drops any byte offered this cycle and overrides load_end.
          byte_idx_d = 2'd0;
          word_d     = '0;
          count_d    = '0;
          ovf_d      = 1'b0;
        end else begin
          if (load_valid && mem_full) begin
            ovf_d = 1'b1;
          end
          if (load_valid && !mem_full) begin
            case (byte_idx_q)
              2'd0:    next_word = {load_byte, 24'h000000};
              2'd1:    next_word = {word_q[31:24], load_byte, 16'h0000};
              2'd2:    next_word = {word_q[31:16], load_byte, 8'h00};
              default: next_word = {word_q[31:8], load_byte};
            endcase
            if (byte_idx_q == 2'd3) begin
              mem_we     = 1'b1;
              mem_wdata  = next_word;
              count_d    = count_q + 1'b1;
              byte_idx_d = 2'd0;
              word_d     = '0;
            end else begin
              word_d     = next_word;
              byte_idx_d = 2'(byte_idx_q + 2'd1);
            end
          end
          if (load_end) begin
            state_d = (byte_idx_d == 2'd0) ? IDLE : FLUSH;
          end
        end
      end

      FLUSH: begin
        // Partial word already has zeroed low bytes because word_q is cleared per word.
        cpu_hold   = 1'b1;
        mem_we     = 1'b1;
        mem_wdata  = word_q;
        count_d    = count_q + 1'b1;
        byte_idx_d = 2'd0;
        word_d     = '0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_idx_q <= 2'd0;
      word_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Contents survive reset so a reset does not wipe a loaded program.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_instr_mem_module.sv
// Directed bench for instr_mem_module: one instance at ADDR_WIDTH=8, one at ADDR_WIDTH=2.
module tb_instr_mem_module;

  logic        clk = 1'b0;
  logic        a_reset = 1'b1;
  logic        b_reset = 1'b1;
  logic [31:0] instr_sel = 32'h0;
  logic        load_start = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_valid = 1'b0;
  logic        load_end = 1'b0;

  logic [31:0] a_instr_out, b_instr_out;
  logic        a_addr_fault, b_addr_fault;
  logic        a_load_ready, b_load_ready;
  logic        a_cpu_hold, b_cpu_hold;
  logic [8:0]  a_load_count;
  logic [2:0]  b_load_count;
  logic        a_load_ovf, b_load_ovf;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  instr_mem_module #(.ADDR_WIDTH(8), .NOP_WORD(32'h00000000)) dut_a (
    .clock(clk), .reset(a_reset), .instr_sel(instr_sel), .instr_out(a_instr_out),
    .addr_fault(a_addr_fault), .load_start(load_start), .load_byte(load_byte),
    .load_valid(load_valid), .load_ready(a_load_ready), .load_end(load_end),
    .cpu_hold(a_cpu_hold), .load_count(a_load_count), .load_ovf(a_load_ovf)
  );

  instr_mem_module #(.ADDR_WIDTH(2), .NOP_WORD(32'h00000000)) dut_b (
    .clock(clk), .reset(b_reset), .instr_sel(instr_sel), .instr_out(b_instr_out),
    .addr_fault(b_addr_fault), .load_start(load_start), .load_byte(load_byte),
    .load_valid(load_valid), .load_ready(b_load_ready), .load_end(load_end),
    .cpu_hold(b_cpu_hold), .load_count(b_load_count), .load_ovf(b_load_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    load_valid = 1'b1;
    load_byte  = b;
    load_end   = e;
    tick();
    load_valid = 1'b0;
    load_end   = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    instr_sel = addr;
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    a_reset = 1'b0;
    #1;
    check("rst_hold", a_cpu_hold, 0);
    check("rst_ready", a_load_ready, 0);
    check("rst_count", a_load_count, 0);
    check("rst_ovf", a_load_ovf, 0);

    // 1: single aligned word
    pulse_start();
    check("t1_hold", a_cpu_hold, 1);
    check("t1_ready", a_load_ready, 1);
    send(8'h20, 0); send(8'h01, 0); send(8'h00, 0); send(8'h05, 0);
    check("t1_count_mid", a_load_count, 1);
    fetch(32'h0);
    check("t1_nop_held", a_instr_out, 32'h0);
    pulse_end();
    check("t1_hold_off", a_cpu_hold, 0);
    check("t1_count", a_load_count, 1);
    fetch(32'h0);
    check("t1_mem0", a_instr_out, 32'h20010005);
    $display("t1 load 4 bytes -> mem0=%h count=%0d", a_instr_out, a_load_count);

    // 2: six bytes, partial word flushed
    pulse_start();
    fetch(32'h0);
    check("t2_nop_held", a_instr_out, 32'h0);
    for (int i = 0; i < 6; i++) send(8'h11 + 8'(i), 0);
    pulse_end();
    check("t2_flush_hold", a_cpu_hold, 1);
    check("t2_flush_ready", a_load_ready, 0);
    check("t2_flush_count", a_load_count, 1);
    tick();
    check("t2_hold_off", a_cpu_hold, 0);
    check("t2_count", a_load_count, 2);
    fetch(32'h0);
    check("t2_mem0", a_instr_out, 32'h11121314);
    fetch(32'h4);
    check("t2_mem1", a_instr_out, 32'h15160000);
    $display("t2 load 6 bytes -> mem1=%h count=%0d", a_instr_out, a_load_count);

    // 4: faulting fetches
    fetch(32'h2);
    check("t4_fault_mis", a_addr_fault, 1);
    check("t4_nop_mis", a_instr_out, 32'h0);
    fetch(32'h400);
    check("t4_fault_oor", a_addr_fault, 1);
    check("t4_nop_oor", a_instr_out, 32'h0);
    fetch(32'h3FC);
    check("t4_fault_top", a_addr_fault, 0);
    $display("t4 fault fetches checked");

    // 5: reset during a load
    pulse_start();
    send(8'hAA, 0); send(8'hBB, 0);
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    #1;
    check("t5_hold", a_cpu_hold, 0);
    check("t5_count", a_load_count, 0);
    check("t5_ready", a_load_ready, 0);
    fetch(32'h0);
    check("t5_mem0", a_instr_out, 32'h11121314);
    fetch(32'h4);
    check("t5_mem1", a_instr_out, 32'h15160000);
    $display("t5 reset mid-load, mem intact");

    // 6: restart mid-word, end on the 4th byte
    pulse_start();
    send(8'h01, 0); send(8'h02, 0);
    pulse_start();
    check("t6_restart_count", a_load_count, 0);
    send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0); send(8'hD4, 1);
    check("t6_no_flush", a_cpu_hold, 0);
    check("t6_count", a_load_count, 1);
    fetch(32'h0);
    check("t6_mem0", a_instr_out, 32'hA1B2C3D4);
    fetch(32'h4);
    check("t6_mem1", a_instr_out, 32'h15160000);
    $display("t6 restart -> mem0=%h count=%0d", a_instr_out, a_load_count);

    // 3: overflow on the 4-word instance
    a_reset = 1'b1;
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    pulse_start();
    for (int i = 1; i <= 16; i++) send(8'(i), 0);
    check("t3_ready_full", b_load_ready, 0);
    check("t3_count_full", b_load_count, 4);
    check("t3_ovf_before", b_load_ovf, 0);
    send(8'd17, 0);
    check("t3_ovf", b_load_ovf, 1);
    check("t3_count_ovf", b_load_count, 4);
    pulse_end();
    check("t3_hold_off", b_cpu_hold, 0);
    check("t3_ovf_held", b_load_ovf, 1);
    fetch(32'hC);
    check("t3_mem3", b_instr_out, 32'h0D0E0F10);
    fetch(32'h0);
    check("t3_mem0", b_instr_out, 32'h01020304);
    fetch(32'h10);
    check("t3_fault_oor", b_addr_fault, 1);
    pulse_start();
    check("t3_ovf_clear", b_load_ovf, 0);
    check("t3_count_clear", b_load_count, 0);
    pulse_end();
    $display("t3 overflow load -> count=%0d ovf cleared on restart", b_load_count);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
